pulse_scheduler: RTL and testbench



---
 rtl/pulse_scheduler_if.sv | 27 ++
 rtl/pulse_scheduler.sv | 142 ++++++++++++++
 tb/tb_pulse_scheduler.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pulse_scheduler_if : request/width and pulse/grant/ack bundle        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pulse_scheduler_if #(
    parameter int N_REQ   = 4,
    parameter int WIDTH_W = 4
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*WIDTH_W-1:0] width;
    logic                     signal;
    logic [N_REQ-1:0]         grant;
    logic [N_REQ-1:0]         ack;
    logic                     busy;

    modport master (
        output req, width,
        input  signal, grant, ack, busy
    );

    modport slave (
        input  req, width,
        output signal, grant, ack, busy
    );
endinterface
`default_nettype wire

// File: rtl/pulse_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pulse_scheduler : round-robin share of one programmable pulse line   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pulse_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH_W = 4,
    parameter int GAP     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    pulse_scheduler_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = 4;
    localparam logic [GAP_W-1:0] c_gap_load = GAP_W'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             r_state, w_state;
    logic [WIDTH_W-1:0] r_cnt, w_cnt;
    logic [GAP_W-1:0]   r_gap, w_gap;
    logic [IDX_W-1:0]   r_ptr, w_ptr;
    logic [IDX_W-1:0]   r_owner, w_owner;
    logic               r_signal, w_signal;
    logic [N_REQ-1:0]   r_grant, w_grant;
    logic [N_REQ-1:0]   r_ack, w_ack;
    logic               r_busy, w_busy;

    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_idx;
    logic [WIDTH_W-1:0] w_sel_width;
    logic [WIDTH_W-1:0] w_load;
    logic [IDX_W-1:0]   w_ptr_inc;

    // First requester at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        w_found     = 1'b0;
        w_sel       = '0;
        w_idx       = '0;
        w_sel_width = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_idx = IDX_W'((int'(r_ptr) + off) % N_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_sel_width = bus.width[i*WIDTH_W +: WIDTH_W];
            end
        end
        w_load    = (w_sel_width == '0) ? WIDTH_W'(1) : w_sel_width;
        w_ptr_inc = IDX_W'((int'(w_sel) + 1) % N_REQ);
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_gap    = r_gap;
        w_ptr    = r_ptr;
        w_owner  = r_owner;
        w_signal = r_signal;
        w_grant  = r_grant;
        w_ack    = '0;
        w_busy   = r_busy;

        case (r_state)
            ST_PULSE: begin
                if (r_cnt == WIDTH_W'(1)) begin
                    w_state         = ST_GAP;
                    w_signal        = 1'b0;
                    w_grant         = '0;
                    w_ack[r_owner]  = 1'b1;
                    w_gap           = c_gap_load;
                end else begin
                    w_cnt = r_cnt - WIDTH_W'(1);
                end
            end
            ST_GAP: begin
                if (r_gap != GAP_W'(1)) begin
                    w_gap = r_gap - GAP_W'(1);
                end else begin
                    w_state = ST_IDLE;
                    w_busy  = 1'b0;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // Arbitration happens from IDLE or on the last gap cycle, so
        // continuous requesters are served every W+GAP cycles.
        if ((r_state == ST_IDLE || (r_state == ST_GAP && r_gap == GAP_W'(1))) && w_found) begin
            w_state  = ST_PULSE;
            w_signal = 1'b1;
            w_busy   = 1'b1;
            w_grant  = N_REQ'(1) << w_sel;
            w_cnt    = w_load;
            w_ptr    = w_ptr_inc;
            w_owner  = w_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_gap    <= '0;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_signal <= 1'b0;
            r_grant  <= '0;
            r_ack    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_gap    <= w_gap;
            r_ptr    <= w_ptr;
            r_owner  <= w_owner;
            r_signal <= w_signal;
            r_grant  <= w_grant;
            r_ack    <= w_ack;
            r_busy   <= w_busy;
        end
    end

    assign bus.signal = r_signal;
    assign bus.grant  = r_grant;
    assign bus.ack    = r_ack;
    assign bus.busy   = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_pulse_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pulse_scheduler : scoreboard bench with a transaction-level model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pulse_scheduler;
    localparam int N_REQ   = 4;
    localparam int WIDTH_W = 4;
    localparam int GAP     = 1;

    logic clk = 1'b0;
    logic rst_n;

    pulse_scheduler_if #(.N_REQ(N_REQ), .WIDTH_W(WIDTH_W)) bus ();

    pulse_scheduler #(.N_REQ(N_REQ), .WIDTH_W(WIDTH_W), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int owner;
        int w;
        int start;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: edge counter, rotation pointer, and the cycle
    // from which the shared line may be granted again.
    int cyc = 0;
    int m_ptr = 0;
    int avail = 0;
    bit have = 0;
    int cur_owner = 0;
    int cur_start = 0;
    int cur_w = 0;

    bit hold = 0;
    bit rnd  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int width_of(input int i);
        int v;
        v = 0;
        for (int j = 0; j < N_REQ; j++) begin
            if (j == i) v = int'(bus.width[j*WIDTH_W +: WIDTH_W]);
        end
        return v;
    endfunction

    task automatic set_width(input int i, input int v);
        for (int j = 0; j < N_REQ; j++) begin
            if (j == i) bus.width[j*WIDTH_W +: WIDTH_W] = WIDTH_W'(v);
        end
    endtask

    // Model: each edge, if the line is free and anyone asks, the first
    // requester from the pointer wins a max(width,1) pulse plus GAP idle.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_ptr = 0;
            avail = 0;
            have  = 0;
            exp_q.delete();
        end else if (cyc >= avail && bus.req != '0) begin
            int   reqv;
            int   pick;
            txn_t t;
            reqv = int'(bus.req);
            pick = -1;
            for (int k = 0; k < N_REQ; k++) begin
                int c;
                c = (m_ptr + k) % N_REQ;
                if (pick < 0 && ((reqv >> c) & 1) == 1) pick = c;
            end
            cur_owner = pick;
            cur_start = cyc;
            cur_w     = (width_of(pick) == 0) ? 1 : width_of(pick);
            have      = 1;
            avail     = cyc + cur_w + GAP;
            m_ptr     = (pick + 1) % N_REQ;
            t.owner   = pick;
            t.w       = cur_w;
            t.start   = cyc;
            exp_q.push_back(t);
        end
    end

    // Monitor: per-cycle output check plus scoreboard pop on each ack.
    initial begin
        bit   prev_sig;
        int   m_start;
        int   m_len;
        int   m_owner;
        int   onehot;
        int   sig_e;
        txn_t t;
        prev_sig = 0;
        m_start  = 0;
        m_len    = 0;
        m_owner  = 0;
        forever begin
            @(negedge clk);
            onehot = have ? (1 << cur_owner) : 0;
            sig_e  = (have && cyc < cur_start + cur_w) ? 1 : 0;
            check("signal", int'(bus.signal), sig_e);
            check("busy",   int'(bus.busy),   (cyc < avail) ? 1 : 0);
            check("grant",  int'(bus.grant),  (sig_e == 1) ? onehot : 0);
            check("ack",    int'(bus.ack),    (have && cyc == cur_start + cur_w) ? onehot : 0);
            if (!rst_n) begin
                prev_sig = 0;
                m_len    = 0;
            end else begin
                if (bus.signal && !prev_sig) begin
                    m_start = cyc;
                    m_len   = 1;
                    m_owner = int'(bus.grant);
                end else if (bus.signal) begin
                    m_len++;
                end
                prev_sig = bus.signal;
                if (bus.ack != '0) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL ack_unexpected: got ack=%0d, expected no pending pulse", bus.ack);
                    end else begin
                        t = exp_q.pop_front();
                        check("ack_owner",   int'(bus.ack), 1 << t.owner);
                        check("grant_owner", m_owner,       1 << t.owner);
                        check("pulse_len",   m_len,         t.w);
                        check("pulse_start", m_start,       t.start);
                    end
                end
            end
        end
    end

    // One cycle of requester behaviour: drop on ack, optional random traffic.
    task automatic step();
        @(negedge clk);
        if (!hold) bus.req = bus.req & ~bus.ack;
        if (rnd) begin
            for (int i = 0; i < N_REQ; i++) begin
                logic [N_REQ-1:0] m;
                m = N_REQ'(1) << i;
                if ((bus.req & m) == '0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_width(i, int'($urandom_range(0, 15)));
                        bus.req = bus.req | m;
                    end
                end else if ((bus.grant & m) != '0 && $urandom_range(0, 29) == 0) begin
                    bus.req = bus.req & ~m;
                end else if ($urandom_range(0, 19) == 0) begin
                    set_width(i, int'($urandom_range(0, 15)));
                end
            end
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((bus.busy || bus.req != '0) && n < bound) begin
            step();
            n++;
        end
        n_cmp++;
        if (n >= bound) begin
            n_bad++;
            $display("FAIL idle_timeout: busy=%0d req=%0d after %0d cycles", bus.busy, bus.req, n);
        end
    endtask

    task automatic wait_grant(input int bound);
        int n;
        n = 0;
        while (bus.grant == '0 && n < bound) begin
            step();
            n++;
        end
        n_cmp++;
        if (n >= bound) begin
            n_bad++;
            $display("FAIL grant_timeout: no grant after %0d cycles", n);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.width = '0;
        repeat (3) step();
        rst_n = 1'b1;

        // single request, width 4
        set_width(0, 4);
        bus.req = 4'b0001;
        wait_idle(40);

        // continuous round robin, all widths 2
        bus.width = {N_REQ{WIDTH_W'(2)}};
        hold      = 1;
        bus.req   = 4'b1111;
        repeat (15) step();
        hold = 0;
        wait_idle(60);

        // width 0, then width 15 changed mid-pulse
        set_width(0, 0);
        bus.req = 4'b0001;
        wait_idle(20);
        set_width(1, 15);
        bus.req = 4'b0010;
        wait_grant(20);
        repeat (5) step();
        set_width(1, 3);
        wait_idle(60);

        // abandoned request mid-pulse
        set_width(2, 6);
        bus.req = 4'b0100;
        wait_grant(20);
        step();
        bus.req = 4'b0000;
        wait_idle(30);
        repeat (5) step();

        // pointer wrap after serving requester 3
        set_width(3, 2);
        bus.req = 4'b1000;
        wait_idle(20);
        set_width(0, 2);
        bus.req = 4'b1001;
        wait_grant(20);
        check("ptr_wrap_grant", int'(bus.grant), 1);
        wait_idle(40);

        // asynchronous reset during a width-10 pulse
        set_width(0, 10);
        bus.req = 4'b0001;
        wait_grant(20);
        repeat (3) step();
        #2;
        rst_n   = 1'b0;
        bus.req = 4'b1010;
        set_width(1, 3);
        set_width(3, 3);
        #1;
        check("rst_async_signal", int'(bus.signal), 0);
        check("rst_async_grant",  int'(bus.grant),  0);
        check("rst_async_busy",   int'(bus.busy),   0);
        check("rst_async_ack",    int'(bus.ack),    0);
        step();
        step();
        rst_n = 1'b1;
        wait_grant(10);
        check("post_reset_first", int'(bus.grant), 2);
        wait_idle(60);

        // randomized traffic
        rnd = 1;
        repeat (3000) step();
        rnd = 0;
        wait_idle(400);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
